// File: rtl/mem_rd_rsp_pkg.sv
// Shared constants, FSM encodings and size helpers for the mem_intf_read responder.
package mem_rd_rsp_pkg;

  localparam int unsigned LINE_BYTES   = 32;
  localparam int unsigned LINE_W       = LINE_BYTES * 8;
  localparam int unsigned MAX_RD_BYTES = 512;
  localparam int unsigned RD_SIZE_W    = $clog2(MAX_RD_BYTES) + 1;
  localparam int unsigned BEATS_W      = $clog2(MAX_RD_BYTES / LINE_BYTES) + 1;
  localparam int unsigned IDX_W        = $clog2(LINE_BYTES);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  // Zero-byte requests read one byte; oversize requests are clamped.
  function automatic logic [RD_SIZE_W-1:0] eff_size(input logic [RD_SIZE_W-1:0] size);
    logic [RD_SIZE_W-1:0] s;
    s = size;
    if (s == '0) s = RD_SIZE_W'(1);
    if (s > RD_SIZE_W'(MAX_RD_BYTES)) s = RD_SIZE_W'(MAX_RD_BYTES);
    return s;
  endfunction

  function automatic logic [BEATS_W-1:0] beats_from_size(input logic [RD_SIZE_W-1:0] size);
    logic [RD_SIZE_W:0] s;
    s = {1'b0, eff_size(size)} + (RD_SIZE_W + 1)'(LINE_BYTES - 1);
    return BEATS_W'(s >> IDX_W);
  endfunction

  function automatic logic [IDX_W-1:0] last_idx_from_size(input logic [RD_SIZE_W-1:0] size);
    logic [RD_SIZE_W-1:0] s;
    s = eff_size(size) - RD_SIZE_W'(1);
    return IDX_W'(s);
  endfunction

endpackage

// File: rtl/mem_rd_rsp_cnt.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
module mem_rd_rsp_cnt #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero_c
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mem_rd_rsp.sv
// mem_intf_read responder: streams line-wide SRAM beats for one read request.
// Optional macro MEM_RD_RSP_STALL_EN adds mem_stall to pause SRAM issue.
module mem_rd_rsp
  import mem_rd_rsp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = 19,
  parameter int unsigned WORD_WIDTH        = 8,
  parameter int unsigned NUM_WORDS_IN_LINE = 32,
  parameter int unsigned MAX_BYTES_TO_RD   = 512,
  parameter int unsigned SIZE_W            = $clog2(MAX_BYTES_TO_RD) + 1,
  parameter int unsigned LINE_ADDR_W       = ADDR_WIDTH - $clog2(NUM_WORDS_IN_LINE)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          mem_req,
  input  logic [ADDR_WIDTH-1:0]                         mem_start_addr,
  input  logic [SIZE_W-1:0]                             mem_size_bytes,
`ifdef MEM_RD_RSP_STALL_EN
  input  logic                                          mem_stall,
`endif
  output logic                                          mem_valid,
  output logic                                          last,
  output logic [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0]  mem_data,
  output logic [$clog2(NUM_WORDS_IN_LINE)-1:0]          mem_last_valid,
  output logic                                          sram_rd_en,
  output logic [LINE_ADDR_W-1:0]                        sram_addr,
  input  logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0]       sram_rdata,
  output logic                                          busy
);

  localparam int unsigned WORD_IDX_W = $clog2(NUM_WORDS_IN_LINE);

  state_t                  state;
  state_t                  state_next;
  logic                    accept_c;
  logic                    issue_go_c;
  logic                    stall_c;
  logic                    final_beat_c;
  logic                    rd_pend;
  logic [LINE_ADDR_W-1:0]  line_q;
  logic [WORD_IDX_W-1:0]   last_idx_q;
  logic [BEATS_W-1:0]      req_beats_c;
  logic [BEATS_W-1:0]      issue_cnt;
  logic [BEATS_W-1:0]      ret_cnt;
  logic                    issue_zero_c;
  logic                    ret_zero_c;
  logic                    unused_c;

`ifdef MEM_RD_RSP_STALL_EN
  assign stall_c = mem_stall;
`else
  assign stall_c = 1'b0;
`endif

  // Lines are aligned, so the byte offset within the line is dropped.
  assign unused_c     = ^mem_start_addr[WORD_IDX_W-1:0];
  assign req_beats_c  = beats_from_size(RD_SIZE_W'(mem_size_bytes));
  assign final_beat_c = rd_pend && (ret_cnt == BEATS_W'(1));

  mem_rd_rsp_cnt #(.W(BEATS_W)) u_issue_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_c),
    .load_val (req_beats_c),
    .dec      (issue_go_c),
    .count    (issue_cnt),
    .zero_c   (issue_zero_c)
  );

  mem_rd_rsp_cnt #(.W(BEATS_W)) u_ret_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_c),
    .load_val (req_beats_c),
    .dec      (rd_pend),
    .count    (ret_cnt),
    .zero_c   (ret_zero_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    issue_go_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_req) begin
          accept_c   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stall_c && !issue_zero_c) begin
          issue_go_c = 1'b1;
          if (issue_cnt == BEATS_W'(1)) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last && ret_zero_c) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        // A still-held request must not be served a second time.
        if (!mem_req) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Issue side, one-cycle SRAM latency tracker, and output beat register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy           <= 1'b0;
      sram_rd_en     <= 1'b0;
      sram_addr      <= '0;
      line_q         <= '0;
      last_idx_q     <= '0;
      rd_pend        <= 1'b0;
      mem_valid      <= 1'b0;
      last           <= 1'b0;
      mem_data       <= '0;
      mem_last_valid <= '0;
    end else begin
      busy       <= (state_next != ST_IDLE);
      sram_rd_en <= issue_go_c;
      rd_pend    <= sram_rd_en;
      mem_valid  <= rd_pend;
      last       <= final_beat_c;
      if (accept_c) begin
        line_q     <= mem_start_addr[ADDR_WIDTH-1:WORD_IDX_W];
        last_idx_q <= WORD_IDX_W'(last_idx_from_size(RD_SIZE_W'(mem_size_bytes)));
      end
      if (issue_go_c) begin
        sram_addr <= line_q;
        line_q    <= line_q + LINE_ADDR_W'(1);
      end
      if (rd_pend) begin
        mem_data       <= sram_rdata;
        mem_last_valid <= final_beat_c ? last_idx_q : '1;
      end
    end
  end

endmodule

// File: tb/tb_mem_rd_rsp.sv
// Scoreboard bench for mem_rd_rsp; stall scenario built when MEM_RD_RSP_STALL_EN is defined.
module tb_mem_rd_rsp;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
    logic [4:0]   lv;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_req;
  logic [18:0]  mem_start_addr;
  logic [9:0]   mem_size_bytes;
  logic         mem_valid;
  logic         last;
  logic [255:0] mem_data;
  logic [4:0]   mem_last_valid;
  logic         sram_rd_en;
  logic [13:0]  sram_addr;
  logic [255:0] sram_rdata;
  logic         busy;
`ifdef MEM_RD_RSP_STALL_EN
  logic         mem_stall;
`endif

  int    n_checks = 0;
  int    errors   = 0;
  int    cyc      = 0;
  beat_t exp_q[$];
  int    beat_cyc[$];

  mem_rd_rsp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_start_addr (mem_start_addr),
    .mem_size_bytes (mem_size_bytes),
`ifdef MEM_RD_RSP_STALL_EN
    .mem_stall      (mem_stall),
`endif
    .mem_valid      (mem_valid),
    .last           (last),
    .mem_data       (mem_data),
    .mem_last_valid (mem_last_valid),
    .sram_rd_en     (sram_rd_en),
    .sram_addr      (sram_addr),
    .sram_rdata     (sram_rdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: every byte of line k holds k[7:0], one cycle after the strobe.
  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= {32{sram_addr[7:0]}};
  end

  // Scoreboard: every valid beat must match the oldest expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (mem_valid === 1'b1) begin
      beat_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%h last=%b lv=%0d, required no beat", mem_data, last, mem_last_valid);
      end else begin
        e = exp_q.pop_front();
        if (mem_data !== e.data || last !== e.last || mem_last_valid !== e.lv) begin
          errors++;
          $display("FAIL beat: got data=%h last=%b lv=%0d, required data=%h last=%b lv=%0d",
                   mem_data, last, mem_last_valid, e.data, e.last, e.lv);
        end
      end
    end
  end

  function automatic int exp_beats(input int size);
    int s;
    s = (size == 0) ? 1 : size;
    if (s > 512) s = 512;
    return (s + 31) / 32;
  endfunction

  task automatic push_req(input logic [18:0] addr, input int size, output int k);
    int    s;
    int    n;
    beat_t b;
    logic [7:0] v;
    s = (size == 0) ? 1 : size;
    if (s > 512) s = 512;
    n = (s + 31) / 32;
    for (int i = 0; i < n; i++) begin
      v      = addr[12:5] + 8'(i);
      b.data = {32{v}};
      b.last = (i == n - 1);
      b.lv   = (i == n - 1) ? 5'((s - 1) % 32) : 5'd31;
      exp_q.push_back(b);
    end
    mem_start_addr = addr;
    mem_size_bytes = 10'(size);
    mem_req        = 1'b1;
    k              = cyc + 1;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (beat_cyc.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    mem_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_valid, last, sram_rd_en, busy} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got valid/last/rd_en/busy=%b, required 0000", {mem_valid, last, sram_rd_en, busy});
    end
    n_checks++;
    if (mem_data !== 256'h0 || mem_last_valid !== 5'd0 || sram_addr !== 14'd0) begin
      errors++; $display("FAIL reset_data: got data=%h lv=%0d addr=%h, required all zero", mem_data, mem_last_valid, sram_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int k;
    bit ok;
    @(posedge clk); #1;
    beat_cyc.delete();
    push_req(19'h00040, 128, k);
    @(posedge clk); #1;
    mem_start_addr = 19'h7FFE0;
    mem_size_bytes = 10'd5;
    n_checks++;
    if (busy !== 1'b1 || sram_rd_en !== 1'b0) begin
      errors++; $display("FAIL basic_accept: got busy=%b rd_en=%b, required busy=1 rd_en=0", busy, sram_rd_en);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sram_rd_en !== 1'b1 || sram_addr !== 14'(2 + i)) begin
        errors++; $display("FAIL basic_issue%0d: got rd_en=%b addr=%h, required 1 %h", i, sram_rd_en, sram_addr, 14'(2 + i));
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (sram_rd_en !== 1'b0) begin
      errors++; $display("FAIL basic_issue_stop: got rd_en=%b, required 0", sram_rd_en);
    end
    wait_beats(4, 20, ok);
    n_checks++;
    if (!ok) begin
      errors++; $display("FAIL basic_timeout: got %0d beats, required 4", beat_cyc.size());
    end else begin
      n_checks++;
      if (beat_cyc[0] !== k + 3 || beat_cyc[3] - beat_cyc[0] !== 3) begin
        errors++; $display("FAIL basic_timing: got first=%0d span=%0d, required first=%0d span=3", beat_cyc[0], beat_cyc[3] - beat_cyc[0], k + 3);
      end
    end
    n_checks++;
    if (mem_valid !== 1'b0 || mem_data !== {32{8'h05}}) begin
      errors++; $display("FAIL basic_hold_data: got valid=%b data=%h, required 0 and line 5 data", mem_valid, mem_data);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL basic_missing: got %0d beats outstanding, required 0", exp_q.size());
    end
    mem_req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL basic_release: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_partial_drop;
    int k;
    bit ok;
    @(posedge clk); #1;
    beat_cyc.delete();
    push_req(19'h00000, 100, k);
    @(posedge clk); #1;
    mem_req = 1'b0;
    wait_beats(4, 20, ok);
    n_checks++;
    if (!ok || busy !== 1'b1) begin
      errors++; $display("FAIL partial_done: got beats=%0d busy=%b, required 4 and busy=1", beat_cyc.size(), busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL partial_release: got busy=%b outstanding=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_size_zero;
    int k;
    bit ok;
    @(posedge clk); #1;
    beat_cyc.delete();
    push_req(19'h00020, 0, k);
    wait_beats(1, 20, ok);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || beat_cyc.size() != 1 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_single: got beats=%0d busy=%b, required 1 beat busy=1", beat_cyc.size(), busy);
    end
    mem_req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL zero_release: got busy=%b outstanding=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_wrap;
    int k;
    bit ok;
    @(posedge clk); #1;
    beat_cyc.delete();
    push_req(19'h7FFE0, 64, k);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (sram_rd_en !== 1'b1 || sram_addr !== 14'h3FFF) begin
      errors++; $display("FAIL wrap_first: got rd_en=%b addr=%h, required 1 3fff", sram_rd_en, sram_addr);
    end
    @(posedge clk); #1;
    n_checks++;
    if (sram_rd_en !== 1'b1 || sram_addr !== 14'h0000) begin
      errors++; $display("FAIL wrap_second: got rd_en=%b addr=%h, required 1 0000", sram_rd_en, sram_addr);
    end
    wait_beats(2, 20, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_beats: got beats=%0d outstanding=%0d, required 2 0", beat_cyc.size(), exp_q.size());
    end
    mem_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_sizes;
    int sz[6];
    int k;
    int n;
    bit ok;
    sz = '{1, 31, 32, 33, 512, 600};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      beat_cyc.delete();
      n = exp_beats(sz[i]);
      push_req(19'(i << 10), sz[i], k);
      wait_beats(n, 40, ok);
      n_checks++;
      if (!ok || exp_q.size() != 0) begin
        errors++; $display("FAIL size%0d_beats: got beats=%0d outstanding=%0d, required %0d 0", sz[i], beat_cyc.size(), exp_q.size(), n);
      end else begin
        n_checks++;
        if (beat_cyc[n-1] - beat_cyc[0] !== n - 1) begin
          errors++; $display("FAIL size%0d_contig: got span=%0d, required %0d", sz[i], beat_cyc[n-1] - beat_cyc[0], n - 1);
        end
      end
      mem_req = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int k;
    bit ok;
    @(posedge clk); #1;
    beat_cyc.delete();
    push_req(19'h00000, 128, k);
    wait_beats(1, 20, ok);
    rst_n   = 1'b0;
    mem_req = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (!ok || mem_valid !== 1'b0 || busy !== 1'b0 || sram_rd_en !== 1'b0) begin
      errors++; $display("FAIL midreset_clear: got valid=%b busy=%b rd_en=%b, required 0 0 0", mem_valid, busy, sram_rd_en);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (beat_cyc.size() != 2) begin
      errors++; $display("FAIL midreset_nobeats: got beats=%0d, required 2", beat_cyc.size());
    end
    beat_cyc.delete();
    push_req(19'h00060, 40, k);
    wait_beats(2, 20, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL midreset_after: got beats=%0d outstanding=%0d, required 2 0", beat_cyc.size(), exp_q.size());
    end
    mem_req = 1'b0;
    @(posedge clk);
  endtask

`ifdef MEM_RD_RSP_STALL_EN
  task automatic test_stall;
    int k;
    bit ok;
    @(posedge clk); #1;
    beat_cyc.delete();
    push_req(19'h00000, 96, k);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_stall = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (sram_rd_en !== 1'b0) begin
      errors++; $display("FAIL stall_suppress: got rd_en=%b, required 0", sram_rd_en);
    end
    @(posedge clk); #1;
    mem_stall = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (sram_rd_en !== 1'b1 || sram_addr !== 14'd1) begin
      errors++; $display("FAIL stall_resume: got rd_en=%b addr=%h, required 1 0001", sram_rd_en, sram_addr);
    end
    wait_beats(3, 20, ok);
    n_checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_timeout: got %0d beats, required 3", beat_cyc.size());
    end else begin
      n_checks++;
      if (beat_cyc[0] !== k + 3 || beat_cyc[1] !== k + 6 || beat_cyc[2] !== k + 7) begin
        errors++; $display("FAIL stall_gap: got %0d %0d %0d, required %0d %0d %0d",
                           beat_cyc[0], beat_cyc[1], beat_cyc[2], k + 3, k + 6, k + 7);
      end
    end
    mem_req = 1'b0;
    @(posedge clk);
  endtask
`endif

  initial begin
    rst_n          = 1'b0;
    mem_req        = 1'b0;
    mem_start_addr = '0;
    mem_size_bytes = '0;
`ifdef MEM_RD_RSP_STALL_EN
    mem_stall      = 1'b0;
`endif
    test_reset();
    test_basic();
    test_partial_drop();
    test_size_zero();
    test_wrap();
    test_sizes();
    test_reset_mid();
`ifdef MEM_RD_RSP_STALL_EN
    test_stall();
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, errors);
    $finish;
  end

endmodule
